// File: rtl/retire_stage.sv
// retire_stage: commits up to three ROB entries per cycle, frees old tags, raises recovery and predictor updates.
package retire_pkg;
    localparam int XLEN = 32;
    localparam int PR_W = 6;
    localparam int ARCH_REGS = 32;
    localparam int DR_W = $clog2(ARCH_REGS);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
        logic [DR_W-1:0] dest_reg;
        logic [PR_W-1:0] Tnew;
        logic [PR_W-1:0] Told;
        logic            is_branch;
        logic            predict_direction;
        logic            precise_state_need;
        logic [XLEN-1:0] target_pc;
        logic            halt;
    } rob_entry_t;
endpackage

module retire_stage
    import retire_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic                                clock,
    input  logic                                reset,
    input  rob_entry_t [2:0]                    retire_entry,
    output logic                                BPRecoverEN,
    output logic [XLEN-1:0]                     recover_pc,
    output logic [ARCH_REGS-1:0][PR_W-1:0]      archi_maptable,
    output logic [2:0]                          free_valid,
    output logic [2:0][PR_W-1:0]                free_preg,
    output logic                                update_EN,
    output logic [XLEN-1:0]                     update_pc,
    output logic                                update_direction,
    output logic [XLEN-1:0]                     update_target,
    output logic                                halted,
    output logic [CNT_W-1:0]                    retire_count
);
    typedef enum logic [1:0] {RUN, RECOVER, HALT} state_t;
    state_t state;

    logic [2:0]                     commit, fv;
    logic [2:0][PR_W-1:0]           fp;
    logic                           go, mis, hlt, br_found, br_en, br_dir;
    logic [XLEN-1:0]                rpc, br_pc, br_tgt;
    logic [1:0]                     cnt;
    logic [ARCH_REGS-1:0][PR_W-1:0] map_n;

    // Scan oldest (slot 2) to youngest; later map writes overwrite earlier ones so the youngest wins.
    always_comb begin
        go = 1'b1;
        commit = '0;
        fv = '0;
        fp = '0;
        mis = 1'b0;
        hlt = 1'b0;
        rpc = '0;
        br_found = 1'b0;
        br_en = 1'b0;
        br_dir = 1'b0;
        br_pc = '0;
        br_tgt = '0;
        map_n = archi_maptable;
        for (int i = 2; i >= 0; i--) begin
            if (go && retire_entry[i].valid) begin
                commit[i] = 1'b1;
                if (retire_entry[i].dest_reg != '0) begin
                    map_n[retire_entry[i].dest_reg] = retire_entry[i].Tnew;
                    fv[i] = 1'b1;
                    fp[i] = retire_entry[i].Told;
                end
                if (retire_entry[i].is_branch && !br_found) begin
                    br_found = 1'b1;
                    br_en = 1'b1;
                    br_pc = retire_entry[i].PC;
                    br_dir = retire_entry[i].precise_state_need ? !retire_entry[i].predict_direction
                                                               : retire_entry[i].predict_direction;
                    br_tgt = retire_entry[i].precise_state_need ? retire_entry[i].target_pc
                           : retire_entry[i].predict_direction ? retire_entry[i].NPC
                           : retire_entry[i].PC + XLEN'(4);
                end
                if (retire_entry[i].halt) begin
                    hlt = 1'b1;
                    go = 1'b0;
                end else if (retire_entry[i].precise_state_need) begin
                    mis = 1'b1;
                    rpc = retire_entry[i].target_pc;
                    go = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
        cnt = {1'b0, commit[0]} + {1'b0, commit[1]} + {1'b0, commit[2]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            BPRecoverEN <= 1'b0;
            recover_pc <= '0;
            free_valid <= '0;
            free_preg <= '0;
            update_EN <= 1'b0;
            update_pc <= '0;
            update_direction <= 1'b0;
            update_target <= '0;
            halted <= 1'b0;
            retire_count <= '0;
            for (int i = 0; i < ARCH_REGS; i++) archi_maptable[i] <= PR_W'(i);
        end else if (state == RUN) begin
            state <= hlt ? HALT : mis ? RECOVER : RUN;
            BPRecoverEN <= mis;
            recover_pc <= rpc;
            archi_maptable <= map_n;
            free_valid <= fv;
            free_preg <= fp;
            update_EN <= br_en;
            update_pc <= br_pc;
            update_direction <= br_dir;
            update_target <= br_tgt;
            halted <= hlt;
            retire_count <= retire_count + CNT_W'(cnt);
        end else begin
            state <= (state == HALT) ? HALT : RUN;
            BPRecoverEN <= 1'b0;
            free_valid <= '0;
            update_EN <= 1'b0;
        end
    end
endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed checks of commit, free, recovery, branch update and halt behaviour.
module tb_retire_stage;
    import retire_pkg::*;

    logic                           clock = 1'b0;
    logic                           reset;
    rob_entry_t [2:0]               ent;
    logic                           BPRecoverEN, update_EN, update_direction, halted;
    logic [XLEN-1:0]                recover_pc, update_pc, update_target;
    logic [ARCH_REGS-1:0][PR_W-1:0] archi_maptable;
    logic [2:0]                     free_valid;
    logic [2:0][PR_W-1:0]           free_preg;
    logic [63:0]                    retire_count;
    int checks = 0;
    int failures = 0;

    retire_stage dut (
        .clock(clock), .reset(reset), .retire_entry(ent),
        .BPRecoverEN(BPRecoverEN), .recover_pc(recover_pc), .archi_maptable(archi_maptable),
        .free_valid(free_valid), .free_preg(free_preg), .update_EN(update_EN),
        .update_pc(update_pc), .update_direction(update_direction), .update_target(update_target),
        .halted(halted), .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    function automatic rob_entry_t mk(input logic [4:0] d, input logic [5:0] tn, input logic [5:0] to);
        rob_entry_t e;
        e = '0;
        e.valid = 1'b1;
        e.dest_reg = d;
        e.Tnew = tn;
        e.Told = to;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        ent = '0;
        step();
        step();
        @(negedge clock);
        reset = 1'b0;
        checks++; if (BPRecoverEN !== 1'b0) begin failures++; $display("FAIL reset_recover got %0h exp 0", BPRecoverEN); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %0h exp 0", halted); end
        checks++; if (retire_count !== 64'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", retire_count); end
        checks++; if (free_valid !== 3'b000) begin failures++; $display("FAIL reset_free_valid got %b exp 000", free_valid); end
        checks++; if (archi_maptable[5] !== 6'd5) begin failures++; $display("FAIL reset_map5 got %0d exp 5", archi_maptable[5]); end
        checks++; if (update_EN !== 1'b0) begin failures++; $display("FAIL reset_update got %0h exp 0", update_EN); end
    endtask

    task automatic test_three();
        @(negedge clock);
        ent[2] = mk(1, 33, 1);
        ent[1] = mk(2, 34, 2);
        ent[0] = mk(3, 35, 3);
        step();
        checks++; if (free_valid !== 3'b111) begin failures++; $display("FAIL three_free_valid got %b exp 111", free_valid); end
        checks++; if (free_preg !== {6'd1, 6'd2, 6'd3}) begin failures++; $display("FAIL three_free_preg got %h exp %h", free_preg, {6'd1, 6'd2, 6'd3}); end
        checks++; if (archi_maptable[1] !== 6'd33 || archi_maptable[2] !== 6'd34 || archi_maptable[3] !== 6'd35) begin failures++; $display("FAIL three_map got %0d/%0d/%0d exp 33/34/35", archi_maptable[1], archi_maptable[2], archi_maptable[3]); end
        checks++; if (retire_count !== 64'd3) begin failures++; $display("FAIL three_count got %0d exp 3", retire_count); end
    endtask

    task automatic test_mispredict();
        @(negedge clock);
        ent[2] = mk(4, 36, 4);
        ent[1] = mk(6, 37, 6);
        ent[1].precise_state_need = 1'b1;
        ent[1].is_branch = 1'b1;
        ent[1].target_pc = 32'h100;
        ent[0] = mk(7, 38, 7);
        step();
        checks++; if (BPRecoverEN !== 1'b1) begin failures++; $display("FAIL mis_recover got %0h exp 1", BPRecoverEN); end
        checks++; if (recover_pc !== 32'h100) begin failures++; $display("FAIL mis_pc got %h exp 100", recover_pc); end
        checks++; if (free_valid !== 3'b110) begin failures++; $display("FAIL mis_free_valid got %b exp 110", free_valid); end
        checks++; if (retire_count !== 64'd5) begin failures++; $display("FAIL mis_count got %0d exp 5", retire_count); end
        checks++; if (archi_maptable[6] !== 6'd37 || archi_maptable[7] !== 6'd7) begin failures++; $display("FAIL mis_map got %0d/%0d exp 37/7", archi_maptable[6], archi_maptable[7]); end
        checks++; if (update_EN !== 1'b1 || update_direction !== 1'b1 || update_target !== 32'h100) begin failures++; $display("FAIL mis_update got %0h/%0h/%h exp 1/1/100", update_EN, update_direction, update_target); end
        @(negedge clock);
        ent[2] = mk(8, 39, 8);
        ent[1] = mk(9, 40, 9);
        ent[0] = mk(10, 41, 10);
        step();
        checks++; if (BPRecoverEN !== 1'b0) begin failures++; $display("FAIL recov_pulse got %0h exp 0", BPRecoverEN); end
        checks++; if (free_valid !== 3'b000) begin failures++; $display("FAIL recov_free got %b exp 000", free_valid); end
        checks++; if (retire_count !== 64'd5) begin failures++; $display("FAIL recov_count got %0d exp 5", retire_count); end
        checks++; if (archi_maptable[8] !== 6'd8) begin failures++; $display("FAIL recov_map8 got %0d exp 8", archi_maptable[8]); end
        checks++; if (update_EN !== 1'b0) begin failures++; $display("FAIL recov_update got %0h exp 0", update_EN); end
    endtask

    task automatic test_same_dest();
        @(negedge clock);
        ent = '0;
        ent[2] = mk(5, 40, 5);
        ent[1] = mk(5, 41, 50);
        step();
        checks++; if (archi_maptable[5] !== 6'd41) begin failures++; $display("FAIL same_map5 got %0d exp 41", archi_maptable[5]); end
        checks++; if (free_valid !== 3'b110 || free_preg[2] !== 6'd5 || free_preg[1] !== 6'd50) begin failures++; $display("FAIL same_free got %b %0d/%0d exp 110 5/50", free_valid, free_preg[2], free_preg[1]); end
        checks++; if (retire_count !== 64'd7) begin failures++; $display("FAIL same_count got %0d exp 7", retire_count); end
    endtask

    task automatic test_dest0_gap();
        @(negedge clock);
        ent = '0;
        ent[2] = mk(0, 60, 7);
        step();
        checks++; if (free_valid !== 3'b000) begin failures++; $display("FAIL d0_free got %b exp 000", free_valid); end
        checks++; if (archi_maptable[0] !== 6'd0) begin failures++; $display("FAIL d0_map0 got %0d exp 0", archi_maptable[0]); end
        checks++; if (retire_count !== 64'd8) begin failures++; $display("FAIL d0_count got %0d exp 8", retire_count); end
        @(negedge clock);
        ent = '0;
        ent[1] = mk(9, 42, 9);
        step();
        checks++; if (retire_count !== 64'd8 || free_valid !== 3'b000) begin failures++; $display("FAIL gap_commit got %0d %b exp 8 000", retire_count, free_valid); end
        checks++; if (archi_maptable[9] !== 6'd9) begin failures++; $display("FAIL gap_map9 got %0d exp 9", archi_maptable[9]); end
    endtask

    task automatic test_branch();
        @(negedge clock);
        ent = '0;
        ent[2] = mk(0, 0, 0);
        ent[2].is_branch = 1'b1;
        ent[2].PC = 32'h20;
        ent[2].NPC = 32'h80;
        ent[2].predict_direction = 1'b1;
        ent[1] = mk(0, 0, 0);
        ent[1].is_branch = 1'b1;
        ent[1].PC = 32'h40;
        step();
        checks++; if (update_EN !== 1'b1 || update_pc !== 32'h20) begin failures++; $display("FAIL br_taken_pc got %0h/%h exp 1/20", update_EN, update_pc); end
        checks++; if (update_direction !== 1'b1 || update_target !== 32'h80) begin failures++; $display("FAIL br_taken_tgt got %0h/%h exp 1/80", update_direction, update_target); end
        checks++; if (BPRecoverEN !== 1'b0 || retire_count !== 64'd10) begin failures++; $display("FAIL br_taken_misc got %0h/%0d exp 0/10", BPRecoverEN, retire_count); end
        @(negedge clock);
        ent = '0;
        ent[2] = mk(0, 0, 0);
        ent[2].is_branch = 1'b1;
        ent[2].PC = 32'h40;
        ent[2].NPC = 32'h90;
        step();
        checks++; if (update_pc !== 32'h40 || update_direction !== 1'b0 || update_target !== 32'h44) begin failures++; $display("FAIL br_nt got %h/%0h/%h exp 40/0/44", update_pc, update_direction, update_target); end
        @(negedge clock);
        ent = '0;
        step();
        checks++; if (update_EN !== 1'b0) begin failures++; $display("FAIL br_idle got %0h exp 0", update_EN); end
    endtask

    task automatic test_halt();
        @(negedge clock);
        ent[2] = mk(11, 61, 11);
        ent[1] = mk(12, 62, 12);
        ent[1].halt = 1'b1;
        ent[1].precise_state_need = 1'b1;
        ent[1].target_pc = 32'h200;
        ent[0] = mk(13, 63, 13);
        step();
        checks++; if (halted !== 1'b1 || BPRecoverEN !== 1'b0) begin failures++; $display("FAIL halt_flag got %0h/%0h exp 1/0", halted, BPRecoverEN); end
        checks++; if (free_valid !== 3'b110 || retire_count !== 64'd13) begin failures++; $display("FAIL halt_commit got %b/%0d exp 110/13", free_valid, retire_count); end
        checks++; if (archi_maptable[12] !== 6'd62 || archi_maptable[13] !== 6'd13) begin failures++; $display("FAIL halt_map got %0d/%0d exp 62/13", archi_maptable[12], archi_maptable[13]); end
        @(negedge clock);
        ent[2] = mk(13, 20, 13);
        ent[2].is_branch = 1'b1;
        ent[1] = mk(14, 21, 14);
        ent[1].precise_state_need = 1'b1;
        ent[0] = mk(15, 22, 15);
        step();
        step();
        checks++; if (free_valid !== 3'b000 || update_EN !== 1'b0 || BPRecoverEN !== 1'b0) begin failures++; $display("FAIL halted_strobes got %b/%0h/%0h exp 000/0/0", free_valid, update_EN, BPRecoverEN); end
        checks++; if (retire_count !== 64'd13 || archi_maptable[13] !== 6'd13 || halted !== 1'b1) begin failures++; $display("FAIL halted_frozen got %0d/%0d/%0h exp 13/13/1", retire_count, archi_maptable[13], halted); end
        @(negedge clock);
        reset = 1'b1;
        ent = '0;
        step();
        @(negedge clock);
        reset = 1'b0;
        checks++; if (halted !== 1'b0 || retire_count !== 64'd0) begin failures++; $display("FAIL halt_reset got %0h/%0d exp 0/0", halted, retire_count); end
        checks++; if (archi_maptable[12] !== 6'd12 || archi_maptable[1] !== 6'd1) begin failures++; $display("FAIL halt_reset_map got %0d/%0d exp 12/1", archi_maptable[12], archi_maptable[1]); end
        @(negedge clock);
        ent[2] = mk(2, 30, 2);
        step();
        checks++; if (retire_count !== 64'd1 || archi_maptable[2] !== 6'd30) begin failures++; $display("FAIL post_reset_run got %0d/%0d exp 1/30", retire_count, archi_maptable[2]); end
    endtask

    initial begin
        reset = 1'b1;
        ent = '0;
        test_reset();
        test_three();
        test_mispredict();
        test_same_dest();
        test_dest0_gap();
        test_branch();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Consumer end of the ROB retire interface: takes up to three retiring ROB entries per cycle, oldest first.
- Commits them to the architectural map table and returns the superseded physical registers to the free list.
- On a mispredicted entry, raises the pipeline-wide recovery pulse and the branch-predictor update.
- Sits between the ROB retire port and the rename (map table, free list), fetch (recovery PC) and branch-predictor blocks.

Parameters:
XLEN, 32, architectural data/PC width
PR_W, 6, physical register tag width
ARCH_REGS, 32, number of architectural registers
CNT_W, 64, width of the retired-instruction counter

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
retire_entry  in  3 x ROB_ENTRY_PACKET  retiring entries; slot 2 oldest, slot 0 youngest; fields consumed: valid, PC, NPC, dest_reg, Tnew, Told, is_branch, predict_direction, precise_state_need, target_pc, halt
BPRecoverEN  out  1  one-cycle recovery pulse to ROB, RS, rename and fetch
recover_pc  out  XLEN  fetch restart PC; valid while BPRecoverEN=1
archi_maptable  out  ARCH_REGS x PR_W  committed map table; rename restores from it on BPRecoverEN
free_valid  out  3  per-slot free-list push enables
free_preg  out  3 x PR_W  tags pushed to the free list
update_EN  out  1  branch-predictor update strobe
update_pc  out  XLEN  PC of the updating branch
update_direction  out  1  resolved direction (1 = taken)
update_target  out  XLEN  resolved target
halted  out  1  set after a halt instruction retires
retire_count  out  CNT_W  total committed instructions

Behaviour:
- Reset values: BPRecoverEN=0, recover_pc=0, free_valid=0, free_preg=0, update_EN=0, update_pc=0, update_direction=0, update_target=0, halted=0, retire_count=0, archi_maptable[i]=i (identity).
- Latency: every output is registered. Input presented at cycle N appears on the outputs at cycle N+1.
- FSM has three states:
  - RUN: processes input.
  - RECOVER: entered on the edge that sets BPRecoverEN. Lasts one cycle. All inputs are ignored because the ROB may still present younger entries retired in that cycle. Always returns to RUN.
  - HALT: absorbing until reset. All inputs ignored, all strobes held at 0.
- Commit scan in RUN: walk slots 2, 1, 0 and stop after the first of these:
  - an entry with valid=0; it and all younger slots are ignored,
  - an entry with precise_state_need=1,
  - an entry with halt=1.
  - The stopping entry itself commits. Younger slots in the same cycle are dropped.
- Each committed entry with dest_reg != 0:
  - archi_maptable[dest_reg] <= Tnew,
  - free_valid[slot]=1 and free_preg[slot]=Told.
  - If several committed slots write the same dest_reg, the youngest committed slot wins.
- dest_reg == 0: no map update and no free.
- retire_count increments by the number of committed entries (0-3), wrapping at 2^CNT_W.
- Mispredict: if the scan stops on precise_state_need=1:
  - next cycle BPRecoverEN=1 and recover_pc=target_pc of that entry,
  - FSM goes to RECOVER.
- Branch update: update_EN=1 for the oldest committed entry with is_branch=1. Only one update per cycle; younger committed branches in the same cycle are not reported.
  - If that entry has precise_state_need=1: update_direction = !predict_direction, update_target = target_pc.
  - Otherwise: update_direction = predict_direction, and update_target = NPC when predict_direction=1, else PC+4.
- Halt: the halt entry commits, halted=1 next cycle, FSM goes to HALT. halt takes priority over precise_state_need on the same entry; no BPRecoverEN is raised.
- archi_maptable output is always the registered state. During the BPRecoverEN cycle it already includes the mispredicting entry's commit.
- Reset mid-operation: reset overrides everything, including an in-flight RECOVER and the HALT state.
- No backpressure: the block accepts whatever the ROB presents every cycle.

Test Plan:
1. Reset, then three valid entries (dest 1/2/3, Tnew 33/34/35, Told 1/2/3) -> next cycle free_valid=111 with free_preg=1,2,3, maptable[1..3]=33,34,35, retire_count=3.
2. Slot 2 valid, slot 1 valid with precise_state_need=1 and target_pc=0x100, slot 0 valid -> next cycle BPRecoverEN=1, recover_pc=0x100, free_valid=110, retire_count=2. The following cycle's input (3 valid) is ignored and BPRecoverEN returns to 0.
3. Slots 2 and 1 both dest 5 (Tnew 40 then 41) -> maptable[5]=41, both Told tags freed.
4. Entry with dest_reg=0 and Told=7 -> free_valid bit 0 and maptable unchanged; retire_count still increments.
5. Branch PC=0x20, predict_direction=1, NPC=0x80, precise_state_need=0 -> update_EN=1, update_pc=0x20, update_direction=1, update_target=0x80, BPRecoverEN=0.
6. Halt in slot 1 with a valid slot 0 -> slot 0 dropped, halted=1, all strobes 0 afterwards, retire_count frozen. Reset then clears halted and restores the identity map.
